// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Purpose  : Shares the single register-file write port among four
//            requesters (ALU, load unit, mul/div unit, trap/special-register
//            unit). Each cycle a round-robin decision picks one pending
//            write. The winner's address and data are registered and driven
//            to the 3-to-8 write decoder with the port write enable. Writes
//            to register 0 complete their handshake but never assert wr_en.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk       in   system clock, rising edge
//            reset     in   synchronous, active-high reset
//            req       in   [NREQ]        per-requester write request
//            req_addr  in   [NREQ*ADDR_W] flattened target register select
//            req_data  in   [NREQ*DATA_W] flattened write data
//            stall     in   register file busy, blocks the next decision
//            gnt       out  [NREQ]        registered one-hot grant pulse
//            wr_en     out  register-file write enable
//            wr_sel    out  [ADDR_W]      register select to the decoder
//            wr_data   out  [DATA_W]      write data to the register file
//            busy      out  some request is pending and not granted now
// ============================================================================
module rf_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 3,
    parameter int NREQ         = 4,
    parameter int ZERO_DISCARD = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     stall,
    output logic [NREQ-1:0]          gnt,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_sel,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     busy
);

    // Pointer width. NREQ is a power of two (fixed at 4), so the modulo
    // wrap of the round-robin scan falls out of plain pointer overflow.
    localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    r_gnt;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_sel;
    logic [DATA_W-1:0]  r_wr_data;
    logic [c_ptr_w-1:0] r_rr_ptr;

    logic [NREQ-1:0]    w_eligible;
    logic               w_found;
    logic [c_ptr_w-1:0] w_win;
    logic [c_ptr_w-1:0] w_idx;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [DATA_W-1:0]  w_win_data;
    logic               w_discard;

    // The requester being granted right now still has its req up (it holds
    // until it sees gnt), so it is masked to avoid granting it twice.
    assign w_eligible = req & ~r_gnt;

    // Round-robin scan starting at r_rr_ptr; first eligible index wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = r_rr_ptr + c_ptr_w'(k);
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_win_addr = req_addr[w_win*ADDR_W +: ADDR_W];
    assign w_win_data = req_data[w_win*DATA_W +: DATA_W];

    // Register 0 is hard-wired zero: grant it, but do not write it.
    assign w_discard  = (ZERO_DISCARD != 0) && (w_win_addr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_sel  <= '0;
            r_wr_data <= '0;
            r_rr_ptr  <= '0;
        end else if (!stall && w_found) begin
            r_gnt     <= NREQ'(1) << w_win;
            r_wr_en   <= !w_discard;
            r_wr_sel  <= w_win_addr;
            r_wr_data <= w_win_data;
            r_rr_ptr  <= w_win + c_ptr_w'(1);
        end else begin
            // Select and data hold their last values; only the strobes drop.
            r_gnt     <= '0;
            r_wr_en   <= 1'b0;
        end
    end

    assign gnt     = r_gnt;
    assign wr_en   = r_wr_en;
    assign wr_sel  = r_wr_sel;
    assign wr_data = r_wr_data;
    assign busy    = |(req & ~r_gnt);

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the register file's single write port among four requesters: ALU, load unit, multiply/divide unit and trap/special-register unit.
- Round-robin selects one pending write per cycle.
- Registers the winner's address and data.
- Drives the 3-bit register select into the register-file 3-to-8 write decoder, plus the port write enable.
- Discards writes to register 0 (hard-wired zero) while still completing the handshake.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 3, register select width; drives the 3-to-8 decoder
NREQ, 4, number of requesters; fixed at 4 in this revision
ZERO_DISCARD, 1, 1 = suppress wr_en for writes to register 0

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester write request; held until grant seen
req_addr  input  NREQ*ADDR_W  flattened target register; requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  NREQ*DATA_W  flattened write data; requester i at bits [i*DATA_W +: DATA_W]
stall  input  1  register file busy; no new grant while high
gnt  output  NREQ  one-hot grant, registered, one-cycle pulse
wr_en  output  1  register-file write enable
wr_sel  output  ADDR_W  register select to the decoder
wr_data  output  DATA_W  write data to the register file
busy  output  1  high when any req is pending and not granted this cycle

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset (sampled at a clk edge): gnt=0, wr_en=0, wr_sel=0, wr_data=0, rr_ptr=0.
  - Reset wins over all other inputs.
  - A grant pending at reset is dropped; the requester must keep req asserted and is re-arbitrated afterwards.
- Eligibility at each edge: eligible = req & ~gnt.
  - The requester granted in the current cycle is masked from the next decision.
  - This prevents double-granting a stale request.
  - Consequence: one requester gets at most one write every 2 cycles.
- Arbitration, at the edge ending cycle t, when stall=0 and eligible != 0:
  - Winner w = first eligible index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Cycle t+1: gnt = one-hot(w), wr_sel = req_addr[w], wr_data = req_data[w].
  - Cycle t+1: wr_en = 1, except wr_en = 0 when ZERO_DISCARD=1 and the address is 0.
  - rr_ptr <= (w+1) mod NREQ.
- Latency: request present in cycle t is written at the end of cycle t+1 at the earliest (1 cycle registered).
- No grant, stall=1 or eligible=0: next cycle gnt=0 and wr_en=0.
  - wr_sel and wr_data hold their previous values.
  - rr_ptr unchanged.
- Stall in the grant cycle does not cancel that write. Stall only blocks the next decision.
- Requester protocol:
  - req, req_addr and req_data stay stable from assertion until the cycle gnt[i]=1.
  - The requester may drop req or present a new request from the cycle after gnt.
  - Withdrawing req before grant is illegal; the bench flags it as an assertion error.
- Same-register conflicts: two requesters targeting one register are serialized in round-robin order. The later grant's value remains in the register file; no merging.
- busy = |(req & ~gnt) combinationally. Used by the pipeline hazard unit.
- Invariants checked by assertions:
  - gnt is one-hot or zero.
  - wr_en implies gnt != 0.
  - wr_en=1 never coincides with wr_sel=0 when ZERO_DISCARD=1.
- rr_ptr wraps 3 -> 0.

Test Plan:
1. Reset, then req=0001, addr0=5, data0=0xDEADBEEF -> next cycle gnt=0001, wr_en=1, wr_sel=5 (decoder out 0x20), wr_data=0xDEADBEEF; following cycle gnt=0, wr_en=0.
2. All four requesters assert continuously with distinct addresses 1,2,3,4 -> grants in order 0,1,2,3,0... one per cycle; no requester granted in consecutive cycles; each write appears exactly once per request.
3. Write to register 0 from requester 2 -> gnt=0100 for one cycle, wr_en=0; next request to addr 7 -> wr_en=1, wr_sel=7.
4. stall=1 for 3 cycles with req=1010 pending -> gnt=0 and wr_en=0 throughout, rr_ptr frozen; stall drops -> requester 1 then requester 3 granted on successive cycles.
5. reset asserted in the same cycle a grant would issue (req=0100) -> gnt=0, wr_en=0, rr_ptr=0 after reset; req held -> granted 1 cycle after reset deasserts.
6. Requesters 0 and 3 both target register 6 with data 0x11 and 0x22, rr_ptr=3 -> requester 3 written first, then requester 0; final register 6 = 0x11.
